// File: rtl/rv32v_pkg.sv
// ---------------------------------------------------------------------------
// rv32v_pkg
//   Shared definitions for the RV32V fetch front end.
//   - XLEN      : instruction / PC width.
//   - NOP_INSTR : canonical NOP (addi x0, x0, 0) placed on the fetch output
//                 whenever no real instruction is available.
//   - state_t   : LOAD / RUN mode of the instruction memory controller.
// ---------------------------------------------------------------------------
package rv32v_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : rv32v_pkg

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
//   Single-port synchronous RAM, DEPTH x W, with a registered read port.
//   Written during program load, read during fetch; the two never happen in
//   the same cycle, so one shared address port is enough.
//
//   Ports:
//     clk    in   rising-edge clock
//     we     in   write enable (mem[addr] <= wdata)
//     re     in   read enable  (rdata <= mem[addr]); rdata holds when low
//     addr   in   AW-bit word index
//     wdata  in   W-bit write data
//     rdata  out  W-bit registered read data
// ---------------------------------------------------------------------------
module imem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: neither the array nor the read register has a reset; a reset would
  // stop the tools mapping them onto block RAM and its output register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule : imem_ram

// File: rtl/inst_mem_ctrl.sv
// ---------------------------------------------------------------------------
// inst_mem_ctrl
//   Instruction memory with a program-load port and a stall/flush-aware
//   fetch port feeding the IF/ID register of the RV32V core.
//
//   Mode FSM: LOAD (after reset) accepts writes through the load port and
//   keeps the fetch outputs at NOP/invalid. A load_done pulse moves to RUN,
//   where the memory is read-only and PC is fetched with one cycle latency.
//   Only reset returns to LOAD.
//
//   RUN priority: stg_en=0 (hold) > flush > fault > normal fetch.
//
//   Ports:
//     clk               in   rising-edge clock
//     reset             in   asynchronous active-low reset
//     load_en           in   program-load write strobe (LOAD only)
//     load_addr         in   AW-bit word index to write
//     load_data         in   instruction word to write
//     load_done         in   one-cycle pulse, LOAD -> RUN
//     stg_en            in   pipeline stage enable, 0 = stall
//     flush             in   squash the fetch taken this cycle
//     PC                in   fetch address (word index or byte address)
//     Instruction_Code  out  fetched instruction, NOP when not valid
//     inst_valid        out  Instruction_Code is a real instruction
//     fetch_fault       out  last fetch was out of range or misaligned
//     run_mode          out  controller is in RUN
// ---------------------------------------------------------------------------
module inst_mem_ctrl #(
  parameter int unsigned                  DEPTH     = 256,
  parameter bit                           BYTE_ADDR = 1'b0,
  parameter logic [rv32v_pkg::XLEN-1:0]   NOP_INSTR = rv32v_pkg::NOP_INSTR,
  parameter int unsigned                  AW        = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_en,
  input  logic [AW-1:0]               load_addr,
  input  logic [rv32v_pkg::XLEN-1:0]  load_data,
  input  logic                        load_done,
  input  logic                        stg_en,
  input  logic                        flush,
  input  logic [rv32v_pkg::XLEN-1:0]  PC,
  output logic [rv32v_pkg::XLEN-1:0]  Instruction_Code,
  output logic                        inst_valid,
  output logic                        fetch_fault,
  output logic                        run_mode
);

  import rv32v_pkg::*;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] word_idx;
  logic            misaligned;
  logic            out_of_range;
  logic            fault;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    word_idx   = PC;
    misaligned = 1'b0;
    if (BYTE_ADDR) begin
      word_idx   = {2'b00, PC[XLEN-1:2]};
      misaligned = (PC[1:0] != 2'b00);
    end
    // Any index bit at or above AW means idx >= DEPTH.
    out_of_range = |word_idx[XLEN-1:AW];
    fault        = misaligned | out_of_range;
  end

  // -------------------------------------------------------------------------
  // Mode FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: if (load_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;   // leaves only through reset
      default: state_d = ST_LOAD;
    endcase
  end

  logic ram_we;
  logic ram_re;
  logic fetch_upd;     // fetch output registers take a new value this edge
  logic valid_d;
  logic fault_d;

  always_comb begin
    run_mode  = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    fetch_upd = 1'b0;
    valid_d   = 1'b0;
    fault_d   = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        // A load_done in the same cycle as load_en still completes the write.
        ram_we = load_en;
      end
      ST_RUN: begin
        run_mode  = 1'b1;
        fetch_upd = stg_en;
        valid_d   = !flush && !fault;
        fault_d   = !flush && fault;
        // Only touch the RAM for a fetch that will actually be shown, so the
        // read register holds across stalls together with the flags.
        ram_re    = stg_en && !flush && !fault;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory
  // -------------------------------------------------------------------------
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_rdata;

  // Load and fetch are mutually exclusive by mode, so one port suffices.
  assign ram_addr = run_mode ? word_idx[AW-1:0] : load_addr;

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (XLEN)
  ) u_imem_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // -------------------------------------------------------------------------
  // Fetch flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (fetch_upd) begin
      inst_valid  <= valid_d;
      fetch_fault <= fault_d;
    end
  end

  // The RAM read register cannot be reset to NOP, so the resettable valid
  // flag selects between it and NOP. Both mux inputs are registers, giving
  // the same timing as a registered output while reset/flush/fault still
  // force NOP immediately.
  assign Instruction_Code = inst_valid ? ram_rdata : NOP_INSTR;

endmodule : inst_mem_ctrl

// File: tb/tb_inst_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_ctrl
//   Two instances share all inputs: one with word-index PC, one with byte
//   PC. A behavioural model (array + mode flag) predicts each output.
// ---------------------------------------------------------------------------
module tb_inst_mem_ctrl;

  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] I1    = 32'h0020_81B3;
  localparam logic [31:0] I2    = 32'h0041_8298;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          load_done = 1'b0;
  logic          stg_en = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   pc = '0;

  logic [31:0] code_w, code_b;
  logic        valid_w, valid_b, fault_w, fault_b, run_w, run_b;

  always #5 clk = ~clk;

  inst_mem_ctrl #(.DEPTH(DEPTH), .BYTE_ADDR(1'b0)) u_dut_w (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done), .stg_en(stg_en),
    .flush(flush), .PC(pc), .Instruction_Code(code_w),
    .inst_valid(valid_w), .fetch_fault(fault_w), .run_mode(run_w)
  );

  inst_mem_ctrl #(.DEPTH(DEPTH), .BYTE_ADDR(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done), .stg_en(stg_en),
    .flush(flush), .PC(pc), .Instruction_Code(code_b),
    .inst_valid(valid_b), .fetch_fault(fault_b), .run_mode(run_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  logic [31:0] e_code [2];
  bit          e_valid [2];
  bit          e_fault [2];

  task automatic model_reset();
    m_run = 1'b0;
    for (int m = 0; m < 2; m++) begin
      e_code[m] = NOP; e_valid[m] = 1'b0; e_fault[m] = 1'b0;
    end
  endtask

  // Applies one rising edge with the inputs currently driven.
  task automatic model_edge();
    longint unsigned p;
    longint unsigned idx;
    bit bad_addr;
    if (!m_run) begin
      if (load_en) m_mem[load_addr] = load_data;
      if (load_done) m_run = 1'b1;
    end else if (stg_en) begin
      p = longint'(pc);
      for (int m = 0; m < 2; m++) begin
        if (m == 0) begin
          idx = p;
          bad_addr = (idx >= DEPTH);
        end else begin
          idx = p / 4;
          bad_addr = (p % 4 != 0) || (idx >= DEPTH);
        end
        if (flush) begin
          e_code[m] = NOP; e_valid[m] = 1'b0; e_fault[m] = 1'b0;
        end else if (bad_addr) begin
          e_code[m] = NOP; e_valid[m] = 1'b0; e_fault[m] = 1'b1;
        end else begin
          e_code[m] = m_mem[int'(idx)]; e_valid[m] = 1'b1; e_fault[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".w_code"},  code_w,  e_code[0]);
    check({tag, ".w_valid"}, {31'd0, valid_w}, {31'd0, e_valid[0]});
    check({tag, ".w_fault"}, {31'd0, fault_w}, {31'd0, e_fault[0]});
    check({tag, ".w_run"},   {31'd0, run_w},   {31'd0, m_run});
    check({tag, ".b_code"},  code_b,  e_code[1]);
    check({tag, ".b_valid"}, {31'd0, valid_b}, {31'd0, e_valid[1]});
    check({tag, ".b_fault"}, {31'd0, fault_b}, {31'd0, e_fault[1]});
    check({tag, ".b_run"},   {31'd0, run_b},   {31'd0, m_run});
  endtask

  // One clock: inputs are sampled at the edge, outputs compared 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr,
                       input bit en, input bit fl);
    pc = addr; stg_en = en; flush = fl;
    cycle(tag);
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 255));
      1:       return 32'($urandom_range(0, 255)) * 4;
      2:       return 32'($urandom_range(0, 1023));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();

    // Reset asserted between edges: outputs at reset values immediately.
    #2 reset = 1'b0;
    #1 compare_all("reset");
    #1 reset = 1'b1;

    // Fetch attempts while still in LOAD do nothing.
    for (int i = 0; i < 5; i++) fetch("pre_run", 32'd0, 1'b1, 1'b0);

    // Program load; final write shares its cycle with load_done.
    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = (i == 1) ? I1 : (i == 2) ? I2 : $urandom;
      load_done = (i == DEPTH - 1);
      stg_en    = 1'b1;
      cycle("load");
    end
    load_en = 1'b0; load_done = 1'b0;
    check("run_after_done", {31'd0, run_w}, 32'd1);
    check("nop_after_done", code_w, NOP);

    // Basic fetches, one cycle latency.
    fetch("pc1", 32'd1, 1'b1, 1'b0);
    check("pc1_const", code_w, I1);
    fetch("pc2", 32'd2, 1'b1, 1'b0);
    check("pc2_const", code_w, I2);

    // Stall holds, then flush squashes.
    fetch("pc1_again", 32'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) fetch("stall", 32'd2, 1'b0, 1'b0);
    check("stall_hold", code_w, I1);
    fetch("stall_flush_lost", 32'd2, 1'b0, 1'b1);
    check("flush_lost_hold", code_w, I1);
    fetch("flush", 32'd2, 1'b1, 1'b1);
    check("flush_nop", code_w, NOP);
    check("flush_invalid", {31'd0, valid_w}, 32'd0);

    // Fault boundaries.
    fetch("pc255", 32'd255, 1'b1, 1'b0);
    fetch("pc256", 32'd256, 1'b1, 1'b0);
    check("oor_fault", {31'd0, fault_w}, 32'd1);
    check("oor_nop", code_w, NOP);
    fetch("pc6", 32'h6, 1'b1, 1'b0);
    check("misalign_fault", {31'd0, fault_b}, 32'd1);
    fetch("pc4", 32'h4, 1'b1, 1'b0);
    check("byte_pc4", code_b, I1);
    fetch("pc1020", 32'd1020, 1'b1, 1'b0);
    fetch("pc1024", 32'd1024, 1'b1, 1'b0);
    fetch("pc_fault_flush", 32'd300, 1'b1, 1'b1);

    // Load port is ignored in RUN.
    load_en = 1'b1; load_addr = 8'd1; load_data = 32'hDEAD_BEEF;
    fetch("load_in_run", 32'd0, 1'b1, 1'b0);
    load_en = 1'b0;
    fetch("pc1_after_ld", 32'd1, 1'b1, 1'b0);
    check("ro_in_run", code_w, I1);

    // Randomized traffic, including ignored load strobes and load_done.
    for (int i = 0; i < 400; i++) begin
      load_en   = ($urandom_range(0, 7) == 0);
      load_addr = AW'($urandom);
      load_data = $urandom;
      load_done = ($urandom_range(0, 15) == 0);
      fetch("rand", rand_pc(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0));
    end
    load_en = 1'b0; load_done = 1'b0;

    // Asynchronous reset in RUN, then restart without reloading.
    fetch("pre_rst", 32'd1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all("async_rst");
    #1 reset = 1'b1;
    load_done = 1'b1;
    fetch("done_only", 32'd2, 1'b1, 1'b0);
    load_done = 1'b0;
    fetch("post_rst_pc2", 32'd2, 1'b1, 1'b0);
    check("retained_pc2", code_w, I2);
    fetch("post_rst_pc8", 32'd8, 1'b1, 1'b0);
    check("retained_pc8", code_b, I2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_inst_mem_ctrl
